// File: rtl/accel_uart_pkg.sv
// Shared types and helpers for the accelerometer UART transmit path.
// A 14-bit measurement travels as two 8N1 bytes, high byte first.
package accel_uart_pkg;

   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned WORD_BITS  = 14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } word_state_e;

   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
   } byte_pair_t;

   // Upper two bits of the high byte are always zero.
   function automatic byte_pair_t pack_word(input logic [WORD_BITS-1:0] x);
      byte_pair_t p;
      p = {2'b00, x};
      return p;
   endfunction

   // LSB is transmitted first: start(0), D0..D7, stop(1).
   function automatic logic [FRAME_BITS-1:0] frame_pack(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

endpackage

// File: rtl/accel_uart_tx_if.sv
// Word-level handshake and serial line of the accelerometer UART transmitter.
// master drives requests (bench / sensor model), slave is the transmitter.
interface accel_uart_tx_if;
   import accel_uart_pkg::*;

   logic                 send;
   logic [WORD_BITS-1:0] Xmeas_in;
   logic                 TX;
   logic                 busy;
   logic                 tx_done;

   modport master (
      output send,
      output Xmeas_in,
      input  TX,
      input  busy,
      input  tx_done
   );

   modport slave (
      input  send,
      input  Xmeas_in,
      output TX,
      output busy,
      output tx_done
   );

endinterface

// File: rtl/uart_tx_byte.sv
// Single 8N1 byte serializer; each bit is held BAUD_DIV clocks.
// A load in the final stop-bit cycle restarts the frame with no idle gap.
module uart_tx_byte
   import accel_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       TX,
   output logic       byte_done
);

   localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);
   localparam logic [3:0]      BitLast = 4'(FRAME_BITS - 1);

   logic                  r_active;
   logic [CntW-1:0]       r_baud_cnt;
   logic [3:0]            r_bit_idx;
   logic [FRAME_BITS-1:0] r_frame;

   logic w_wrap;
   logic w_last_bit;

   assign w_wrap     = (r_baud_cnt == CntLast);
   assign w_last_bit = (r_bit_idx == BitLast);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_active   <= 1'b0;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_frame    <= '0;
      end else if (load) begin
         r_active   <= 1'b1;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_frame    <= frame_pack(data);
      end else if (r_active) begin
         if (w_wrap) begin
            r_baud_cnt <= '0;
            if (w_last_bit) begin
               r_active  <= 1'b0;
               r_bit_idx <= '0;
            end else begin
               r_bit_idx <= r_bit_idx + 4'd1;
               r_frame   <= {1'b1, r_frame[FRAME_BITS-1:1]};
            end
         end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
         end
      end
   end

   // Frame bit 0 is the bit currently on the line; idle forces mark.
   assign TX        = r_active ? r_frame[0] : 1'b1;
   assign byte_done = r_active && w_wrap && w_last_bit;

endmodule

// File: rtl/accel_uart_tx.sv
// Word-level transmitter: latches a 14-bit measurement and sends high then low byte.
// Holds the word FSM, the low-byte latch and the busy / tx_done logic.
module accel_uart_tx
   import accel_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic           clk,
   input  logic           rst_n,
   accel_uart_tx_if.slave bus
);

   word_state_e r_state;
   word_state_e w_state_d;
   logic [7:0]  r_lo_byte;
   logic        r_tx_done;

   byte_pair_t  w_pair;
   logic        w_accept;
   logic        w_load;
   logic [7:0]  w_byte_data;
   logic        w_byte_done;
   logic        w_tx_done_d;
   logic        w_busy;
   logic        w_tx;

   assign w_pair = pack_word(bus.Xmeas_in);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_lo_byte <= '0;
         r_tx_done <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_tx_done <= w_tx_done_d;
         if (w_accept) begin
            r_lo_byte <= w_pair.lo;
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         IDLE:    if (bus.send)   w_state_d = HIGH;
         HIGH:    if (w_byte_done) w_state_d = LOW;
         LOW:     if (w_byte_done) w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   // The high byte goes out straight from the input in the accept cycle;
   // only the low byte needs to be held for the second frame.
   always_comb begin
      w_accept    = (r_state == IDLE) && bus.send;
      w_load      = w_accept || ((r_state == HIGH) && w_byte_done);
      w_byte_data = (r_state == HIGH) ? r_lo_byte : w_pair.hi;
      w_tx_done_d = (r_state == LOW) && w_byte_done;
      w_busy      = (r_state == HIGH) || (r_state == LOW);
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tx_byte (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load),
      .data      (w_byte_data),
      .TX        (w_tx),
      .byte_done (w_byte_done)
   );

   assign bus.TX      = w_tx;
   assign bus.busy    = w_busy;
   assign bus.tx_done = r_tx_done;

endmodule

// File: tb/tb_accel_uart_tx.sv
// Directed bench for accel_uart_tx at BAUD_DIV=4: vector table plus corner sequences.
// Each word's 80-cycle line waveform is compared against a bit-level reference.
module tb_accel_uart_tx;

   localparam int unsigned BD  = 4;
   localparam int          NCY = 20 * BD;

   typedef struct {
      logic [13:0] x;
      logic [7:0]  hi;
      logic [7:0]  lo;
      int          spam_cycle;
      logic [13:0] spam_x;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   vec_t vecs [6];

   accel_uart_tx_if bus ();

   accel_uart_tx #(
      .BAUD_DIV (BD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Line level expected in cycle c (1-based) of a word transfer.
   function automatic logic exp_bit(input logic [7:0] hi, input logic [7:0] lo, input int c);
      int idx;
      int b;
      logic [7:0] byt;
      idx = (c - 1) / BD;
      b   = idx % 10;
      byt = (idx < 10) ? hi : lo;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return byt[b-1];
   endfunction

   // Called in cycle 1 after accept; returns in the tx_done cycle.
   task automatic capture(input string name, input logic [7:0] hi, input logic [7:0] lo,
                          input int spam_cycle, input logic [13:0] spam_x,
                          output logic [7:0] got_hi, output logic [7:0] got_lo);
      logic s [1:NCY];
      int   mism;
      int   busy_cnt;
      int   done_cnt;
      mism     = 0;
      busy_cnt = 0;
      done_cnt = 0;
      for (int c = 1; c <= NCY; c++) begin
         s[c] = bus.TX;
         if (bus.TX !== exp_bit(hi, lo, c)) mism++;
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.tx_done !== 1'b0) done_cnt++;
         if (spam_cycle != 0 && c == spam_cycle) begin
            bus.send     = 1'b1;
            bus.Xmeas_in = spam_x;
         end else if (spam_cycle != 0 && c == spam_cycle + 1) begin
            bus.send = 1'b0;
         end
         tick();
      end
      if (spam_cycle != 0) bus.send = 1'b0;
      for (int j = 0; j < 8; j++) begin
         got_hi[j] = s[BD * (1 + j) + 2];
         got_lo[j] = s[BD * (11 + j) + 2];
      end
      chk($sformatf("%s_wave_mismatches", name), mism, 0);
      chk($sformatf("%s_busy_cycles", name), busy_cnt, NCY);
      chk($sformatf("%s_early_done", name), done_cnt, 0);
      chk($sformatf("%s_hi_byte", name), {24'd0, got_hi}, {24'd0, hi});
      chk($sformatf("%s_lo_byte", name), {24'd0, got_lo}, {24'd0, lo});
      chk($sformatf("%s_done_pulse", name), {31'd0, bus.tx_done}, 1);
      chk($sformatf("%s_busy_at_done", name), {31'd0, bus.busy}, 0);
      chk($sformatf("%s_tx_at_done", name), {31'd0, bus.TX}, 1);
   endtask

   task automatic run_word(input string name, input logic [13:0] x, input logic [7:0] hi,
                           input logic [7:0] lo, input int spam_cycle,
                           input logic [13:0] spam_x);
      logic [7:0] gh;
      logic [7:0] gl;
      bus.Xmeas_in = x;
      bus.send     = 1'b1;
      tick();
      bus.send     = 1'b0;
      bus.Xmeas_in = ~x;
      capture(name, hi, lo, spam_cycle, spam_x, gh, gl);
      tick();
      chk($sformatf("%s_idle_after", name), {29'd0, bus.TX, bus.busy, bus.tx_done}, 3'b100);
   endtask

   initial begin
      logic [7:0]  gh;
      logic [7:0]  gl;
      logic [13:0] rx;
      int          stray;
      checks = 0;
      errors = 0;

      vecs[0] = '{x: 14'h2A5C, hi: 8'h2A, lo: 8'h5C, spam_cycle: 0,  spam_x: 14'h0000};
      vecs[1] = '{x: 14'h3FFF, hi: 8'h3F, lo: 8'hFF, spam_cycle: 0,  spam_x: 14'h0000};
      vecs[2] = '{x: 14'h0000, hi: 8'h00, lo: 8'h00, spam_cycle: 0,  spam_x: 14'h3FFF};
      vecs[3] = '{x: 14'h2A5C, hi: 8'h2A, lo: 8'h5C, spam_cycle: 30, spam_x: 14'h1111};
      vecs[4] = '{x: 14'h1555, hi: 8'h15, lo: 8'h55, spam_cycle: 1,  spam_x: 14'h2AAA};
      vecs[5] = '{x: 14'h0A81, hi: 8'h0A, lo: 8'h81, spam_cycle: 80, spam_x: 14'h3FFF};

      bus.send     = 1'b0;
      bus.Xmeas_in = '0;
      rst_n        = 1'b0;
      tick();
      tick();
      chk("reset_tx", {31'd0, bus.TX}, 1);
      chk("reset_busy", {31'd0, bus.busy}, 0);
      chk("reset_done", {31'd0, bus.tx_done}, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_tx", {31'd0, bus.TX}, 1);

      for (int i = 0; i < 6; i++) begin
         run_word($sformatf("vec%0d", i), vecs[i].x, vecs[i].hi, vecs[i].lo,
                  vecs[i].spam_cycle, vecs[i].spam_x);
      end

      // send held high across two words: second start in the cycle after tx_done
      bus.Xmeas_in = 14'h0123;
      bus.send     = 1'b1;
      tick();
      bus.Xmeas_in = 14'h2ABC;
      capture("b2b_first", 8'h01, 8'h23, 0, 14'h0000, gh, gl);
      chk("b2b_first_word", {18'd0, gh[5:0], gl}, 32'h0123);
      tick();
      bus.send = 1'b0;
      chk("b2b_restart_busy", {31'd0, bus.busy}, 1);
      capture("b2b_second", 8'h2A, 8'hBC, 0, 14'h0000, gh, gl);
      chk("b2b_second_word", {18'd0, gh[5:0], gl}, 32'h2ABC);
      tick();

      // reset in cycle 45 abandons the transfer
      bus.Xmeas_in = 14'h2A5C;
      bus.send     = 1'b1;
      tick();
      bus.send = 1'b0;
      repeat (44) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_tx", {31'd0, bus.TX}, 1);
      chk("midrst_busy", {31'd0, bus.busy}, 0);
      chk("midrst_done", {31'd0, bus.tx_done}, 0);
      stray = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (bus.tx_done !== 1'b0 || bus.busy !== 1'b0 || bus.TX !== 1'b1) stray++;
      end
      chk("midrst_quiet", stray, 0);
      run_word("post_rst", 14'h0055, 8'h00, 8'h55, 0, 14'h0000);

      // loopback: rebuild each random word from the decoded byte pair
      for (int n = 0; n < 100; n++) begin
         rx           = 14'($urandom);
         bus.Xmeas_in = rx;
         bus.send     = 1'b1;
         tick();
         bus.send = 1'b0;
         capture($sformatf("rnd%0d", n), {2'b00, rx[13:8]}, rx[7:0], 0, 14'h0000, gh, gl);
         chk($sformatf("rnd%0d_word", n), {18'd0, gh[5:0], gl}, {18'd0, rx});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
